imem_fetch_ctrl: RTL and testbench

Sequences the byte-wide instruction memory (8-bit data, synchronous registered read with rd_en) for the RISC-V core.
- Fetch path: turns a single fetch request for a 32-bit instruction into four byte reads, then assembles the bytes little-endian.
- Load path: arbitrates the memory port with a byte-serial program loader, so the same memory serves both program load and fetch.
- Sits between the PC/fetch stage and the instruction memory; owns every memory control signal.

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_fetch_ctrl.sv | 92 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory fetch controller.
package imem_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} imem_fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: byte-serial fetch of 32-bit instructions and loader arbitration on one memory port.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = BYTE_W,
  parameter int INSTR_WIDTH = INSTR_BYTES * BYTE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_ready,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_ready,
  output logic                   misaligned,
  input  logic                   load_valid,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   load_ready,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
  output logic [DATA_WIDTH-1:0]  mem_wr_data
);
  imem_fetch_state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, byte_sel;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic valid_q, valid_d, mis_q, mis_d, rd_en_q, rd_en_d, idle, accept;
  assign idle        = state_q == IDLE;
  assign load_ready  = idle;
  assign fetch_ready = idle && !load_valid;
  assign accept      = fetch_req && fetch_ready;
  assign mem_wr_en   = idle && load_valid;
  assign mem_wr_addr = load_addr;
  assign mem_wr_data = load_data;
  assign mem_rd_addr = (state_q == READ) ? base_q + ADDR_WIDTH'(cnt_q) : base_q;
  assign mem_rd_en   = rd_en_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign misaligned  = mis_q;
  assign byte_sel    = cnt_q - 2'd1;
  // Read data lags the address by one cycle, so READ with cnt=k stores byte k-1 and DRAIN stores byte 3.
  always_comb begin
    state_d = idle ? (accept ? READ : IDLE) :
              (state_q == READ) ? (cnt_q == 2'd3 ? DRAIN : READ) :
              (state_q == DRAIN) ? DONE : (instr_ready ? IDLE : DONE);
    cnt_d   = cnt_q;
    base_d  = base_q;
    instr_d = instr_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    if (accept) begin
      base_d = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
      mis_d  = |fetch_addr[1:0];
      cnt_d  = 2'd0;
    end
    if (state_q == READ) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q != 2'd0) instr_d[{byte_sel, 3'b000} +: BYTE_W] = mem_rd_data;
    end
    if (state_q == DRAIN) begin
      instr_d[INSTR_WIDTH-1 -: BYTE_W] = mem_rd_data;
      valid_d = 1'b1;
    end
    if (state_q == DONE && instr_ready) valid_d = 1'b0;
    rd_en_d = state_d == READ;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      rd_en_q <= rd_en_d;
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed table-driven bench with a byte memory model behind the controller.
module tb_imem_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, fetch_req, fetch_ready, instr_valid, instr_ready, misaligned;
  logic load_valid, load_ready, mem_rd_en, mem_wr_en, mem_clr;
  logic [7:0] fetch_addr, load_addr, load_data, mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic [31:0] instr;
  logic [7:0] mem [256];
  logic [7:0] rd_log [$];
  int pass_cnt = 0;
  int total = 0;

  typedef struct {
    bit         is_fetch;
    logic [7:0] addr;
    logic [7:0] data;
    logic [31:0] exp_instr;
    bit         exp_mis;
  } vec_t;
  vec_t vecs [18];

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready), .misaligned(misaligned),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    load_valid = 1'b1; load_addr = a; load_data = d;
    #1;
    chk("load_ready", {31'd0, load_ready}, 32'd1);
    chk("load_wr_en", {31'd0, mem_wr_en}, 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic issue(input logic [7:0] a);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a;
    #1;
    chk("fetch_ready", {31'd0, fetch_ready}, 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    rd_log.delete();
  endtask

  task automatic wait_valid(input logic [7:0] a);
    int lat = 0;
    logic [7:0] base;
    base = {a[7:2], 2'b00};
    while (!instr_valid && lat < 20) begin
      if (mem_rd_en) rd_log.push_back(mem_rd_addr);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 5);
    chk("rd_count", rd_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rd_log.size()) chk("rd_addr", {24'd0, rd_log[i]}, {24'd0, base + 8'(i)});
  endtask

  task automatic finish_fetch();
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("valid_clear", {31'd0, instr_valid}, 32'd0);
  endtask

  task automatic do_fetch(input logic [7:0] a, input logic [31:0] exp_i, input bit exp_m);
    issue(a);
    wait_valid(a);
    chk("instr", instr, exp_i);
    chk("misaligned", {31'd0, misaligned}, {31'd0, exp_m});
    finish_fetch();
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; fetch_req = 1'b0; fetch_addr = '0; instr_ready = 1'b0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    vecs[0]  = '{0, 8'h10, 8'h13, 32'h0, 0};
    vecs[1]  = '{0, 8'h11, 8'h05, 32'h0, 0};
    vecs[2]  = '{0, 8'h12, 8'hA0, 32'h0, 0};
    vecs[3]  = '{0, 8'h13, 8'h00, 32'h0, 0};
    vecs[4]  = '{1, 8'h10, 8'h00, 32'h00A00513, 0};
    vecs[5]  = '{1, 8'h12, 8'h00, 32'h00A00513, 1};
    vecs[6]  = '{0, 8'hFC, 8'hEF, 32'h0, 0};
    vecs[7]  = '{0, 8'hFD, 8'hBE, 32'h0, 0};
    vecs[8]  = '{0, 8'hFE, 8'hAD, 32'h0, 0};
    vecs[9]  = '{0, 8'hFF, 8'hDE, 32'h0, 0};
    vecs[10] = '{1, 8'hFC, 8'h00, 32'hDEADBEEF, 0};
    vecs[11] = '{1, 8'hFF, 8'h00, 32'hDEADBEEF, 1};
    vecs[12] = '{0, 8'h20, 8'h93, 32'h0, 0};
    vecs[13] = '{0, 8'h21, 8'h00, 32'h0, 0};
    vecs[14] = '{0, 8'h22, 8'h10, 32'h0, 0};
    vecs[15] = '{0, 8'h23, 8'h00, 32'h0, 0};
    vecs[16] = '{1, 8'h20, 8'h00, 32'h00100093, 0};
    vecs[17] = '{1, 8'h23, 8'h00, 32'h00100093, 1};
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].is_fetch) do_fetch(vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_mis);
      else do_load(vecs[i].addr, vecs[i].data);
    end
    // Loader and fetch collide: loader wins, fetch follows once load_valid drops.
    @(negedge clk);
    load_valid = 1'b1; load_addr = 8'h30; load_data = 8'h55;
    fetch_req = 1'b1; fetch_addr = 8'h30;
    #1;
    chk("coll_fetch_ready", {31'd0, fetch_ready}, 32'd0);
    chk("coll_wr_en", {31'd0, mem_wr_en}, 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk("coll_fetch_ready2", {31'd0, fetch_ready}, 32'd1);
    @(negedge clk);
    fetch_req = 1'b0;
    rd_log.delete();
    wait_valid(8'h30);
    chk("coll_instr", instr, 32'h00000055);
    finish_fetch();
    // Backpressure: DONE holds while a pending load waits.
    issue(8'h10);
    wait_valid(8'h10);
    load_valid = 1'b1; load_addr = 8'h40; load_data = 8'hAA;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, 32'h00A00513);
      chk("bp_load_ready", {31'd0, load_ready}, 32'd0);
      chk("bp_wr_en", {31'd0, mem_wr_en}, 32'd0);
      @(negedge clk);
    end
    chk("bp_mem_untouched", {24'd0, mem[8'h40]}, 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    chk("bp_valid_clear", {31'd0, instr_valid}, 32'd0);
    chk("bp_wr_after", {31'd0, mem_wr_en}, 32'd1);
    @(negedge clk);
    load_valid = 1'b0;
    chk("bp_mem_written", {24'd0, mem[8'h40]}, 32'h000000AA);
    // Reset while READ has cnt=2.
    issue(8'h20);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("mid_rst_idle", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_fetch(8'h20, 32'h00100093, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
